// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register file with write-back scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ADDRESS_WIDTH = 5;
  localparam int unsigned REG_ZERO      = 0;
  localparam int unsigned REG_A0        = 10;

  typedef logic [ADDRESS_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_scoreboard.sv
// One busy bit per register: set on issue, cleared on write-back; bit 0 is never busy.
module scoreboard #(
  parameter int unsigned ADDRESS_WIDTH = regfile_scoreboard_pkg::ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [ADDRESS_WIDTH-1:0] set_idx,
  input  logic                     clr_en,
  input  logic [ADDRESS_WIDTH-1:0] clr_idx,
  input  logic [ADDRESS_WIDTH-1:0] query1_idx,
  input  logic [ADDRESS_WIDTH-1:0] query2_idx,
  output logic                     query1_busy,
  output logic                     query2_busy
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Set is applied after clear so a same-index issue (the newer instruction) wins.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign query1_busy = busy[query1_idx];
  assign query2_busy = busy[query2_idx];

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-back bypass, busy scoreboard and a0 display copy.
module regfile_scoreboard #(
  parameter int unsigned DATA_WIDTH    = regfile_scoreboard_pkg::DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = regfile_scoreboard_pkg::ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] AD1,
  input  logic [ADDRESS_WIDTH-1:0] AD2,
  output logic [DATA_WIDTH-1:0]    RD1,
  output logic [DATA_WIDTH-1:0]    RD2,
  input  logic                     WE3,
  input  logic [ADDRESS_WIDTH-1:0] AD3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  input  logic                     issue_valid,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     stall,
  output logic [DATA_WIDTH-1:0]    a0
);
  import regfile_scoreboard_pkg::*;

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_en;
  logic                  hit1;
  logic                  hit2;
  logic                  sb_busy1;
  logic                  sb_busy2;

  assign wr_en = WE3 && (AD3 != ADDRESS_WIDTH'(REG_ZERO));
  assign hit1  = wr_en && (AD3 == AD1);
  assign hit2  = wr_en && (AD3 == AD2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      a0 <= '0;
    end else if (wr_en) begin
      regs[AD3] <= WD3;
      if (AD3 == ADDRESS_WIDTH'(REG_A0)) a0 <= WD3;
    end
  end

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (AD1 != ADDRESS_WIDTH'(REG_ZERO)) RD1 = hit1 ? WD3 : regs[AD1];
    if (AD2 != ADDRESS_WIDTH'(REG_ZERO)) RD2 = hit2 ? WD3 : regs[AD2];
  end

  scoreboard #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (issue_valid),
    .set_idx     (issue_rd),
    .clr_en      (WE3),
    .clr_idx     (AD3),
    .query1_idx  (AD1),
    .query2_idx  (AD2),
    .query1_busy (sb_busy1),
    .query2_busy (sb_busy2)
  );

  // A same-cycle write-back to the queried register releases it combinationally.
  assign busy1 = sb_busy1 && !(WE3 && (AD3 == AD1));
  assign busy2 = sb_busy2 && !(WE3 && (AD3 == AD2));
  assign stall = busy1 || busy2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  AD1, AD2, AD3, issue_rd;
  logic [31:0] RD1, RD2, WD3, a0;
  logic        WE3, issue_valid, busy1, busy2, stall;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] mreg  [32];
  bit          mbusy [32];
  logic [31:0] ma0;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AD1        (AD1),
    .AD2        (AD2),
    .RD1        (RD1),
    .RD2        (RD2),
    .WE3        (WE3),
    .AD3        (AD3),
    .WD3        (WD3),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .busy1      (busy1),
    .busy2      (busy2),
    .stall      (stall),
    .a0         (a0)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int a);
    if (a == 0) return 32'h0;
    if (WE3 && int'(AD3) == a) return WD3;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    return mbusy[a] && !(WE3 && int'(AD3) == a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = 32'h0;
      mbusy[i] = 1'b0;
    end
    ma0 = 32'h0;
  endtask

  task automatic check_outputs();
    logic b1, b2;
    b1 = exp_busy(int'(AD1));
    b2 = exp_busy(int'(AD2));
    check_value("rd1",   RD1,   exp_rd(int'(AD1)));
    check_value("rd2",   RD2,   exp_rd(int'(AD2)));
    check_value("busy1", {31'h0, busy1}, {31'h0, b1});
    check_value("busy2", {31'h0, busy2}, {31'h0, b2});
    check_value("stall", {31'h0, stall}, {31'h0, b1 | b2});
    check_value("a0",    a0,    ma0);
  endtask

  // Drive one cycle at the falling edge (also releasing any held reset), check, then advance the model.
  task automatic apply(input logic we, input logic [4:0] ad3, input logic [31:0] wd3,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] ad1, input logic [4:0] ad2);
    @(negedge clk);
    rst_n = 1'b1;
    WE3 = we; AD3 = ad3; WD3 = wd3;
    issue_valid = iv; issue_rd = ird;
    AD1 = ad1; AD2 = ad2;
    #1;
    check_outputs();
    @(posedge clk);
    if (WE3 && AD3 != 5'd0) begin
      mreg[AD3]  = WD3;
      mbusy[AD3] = 1'b0;
      if (AD3 == 5'd10) ma0 = WD3;
    end
    if (issue_valid && issue_rd != 5'd0) mbusy[issue_rd] = 1'b1;
  endtask

  // Reset asserted between edges; everything must read zero at once. Released by the next apply.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    WE3 = 1'b0;
    issue_valid = 1'b0;
    #1;
    model_clear();
    check_value("rst_a0",    a0, 32'h0);
    check_value("rst_stall", {31'h0, stall}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      AD1 = 5'(i);
      AD2 = 5'(31 - i);
      #1;
      check_outputs();
    end
  endtask

  function automatic logic [4:0] rand_idx();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst_n = 1'b0;
    WE3 = 1'b0; AD3 = '0; WD3 = '0;
    issue_valid = 1'b0; issue_rd = '0;
    AD1 = '0; AD2 = '0;
    model_clear();

    // Power-on reset and full read sweep.
    do_reset();

    // Write to index 0 is discarded.
    apply(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    #1 check_value("s2_rd1_after", RD1, 32'h0);
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Bypass then stored value.
    apply(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0);
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    #1 check_value("s3_rd1_stored", RD1, 32'h12345678);

    // Issue to 7, observe stall, release via write-back.
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0);
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7);
    #1 check_value("s4_stall", {31'h0, stall}, 32'h1);
    apply(1'b1, 5'd7, 32'h00000777, 1'b0, 5'd0, 5'd0, 5'd7);
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7);
    #1 check_value("s4_busy2_cleared", {31'h0, busy2}, 32'h0);

    // Same-index issue and write-back: write lands, busy stays set.
    apply(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd0, 5'd0);
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    #1 check_value("s5_busy1", {31'h0, busy1}, 32'h1);
    check_value("s5_rd1", RD1, 32'hA5A5A5A5);

    // a0 copy, then mid-run reset with busy bits pending.
    apply(1'b1, 5'd10, 32'h000000FF, 1'b1, 5'd12, 5'd10, 5'd12);
    #1 check_value("s6_a0", a0, 32'h000000FF);
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd12, 5'd10);
    do_reset();

    // Randomized traffic with occasional resets; release cycle carries live traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      apply(1'($urandom_range(0, 1)), rand_idx(), $urandom(),
            1'($urandom_range(0, 9) < 4), rand_idx(), rand_idx(), rand_idx());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    n_fails++;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
